// File: rtl/gpio_input_unit_pkg.sv
// Shared constants and helpers for the GPIO input unit.
// Flag/enable bit positions and default geometry.
package gpio_input_unit_pkg;

  localparam int DATA_WIDTH_DEF  = 8;
  localparam int SYNC_STAGES_DEF = 2;

  localparam int PCIF0_BIT = 0;
  localparam int PCIF1_BIT = 1;
  localparam int PCIE0_BIT = 0;
  localparam int PCIE1_BIT = 1;

  // A set in the same cycle as a clear wins, so no change event is lost.
  function automatic logic flag_next(
    input logic cur,
    input logic set,
    input logic clr
  );
    return set | (cur & ~clr);
  endfunction

endpackage

// File: rtl/gpio_sync_edge.sv
// Per-port pin synchroniser, previous-sample register
// and masked any-edge change detect.
module gpio_sync_edge #(
  parameter int DATA_WIDTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] i_pin,
  input  logic [DATA_WIDTH-1:0] i_mask,
  output logic [DATA_WIDTH-1:0] o_pin,
  output logic                  o_chg
);

  logic [SYNC_STAGES-1:0][DATA_WIDTH-1:0] r_sync;
  logic [DATA_WIDTH-1:0]                  r_prev;
  logic [DATA_WIDTH-1:0]                  w_diff;

  // r_sync[0] is the raw capture, the top stage is the usable level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= '0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_pin};
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign o_pin  = r_sync[SYNC_STAGES-1];
  assign w_diff = o_pin ^ r_prev;
  assign o_chg  = |(w_diff & i_mask);

endmodule

// File: rtl/gpio_input_unit.sv
// GPIO input side: PINA/PINB synchronisation and
// pin-change interrupt flags PCIF0/PCIF1.
module gpio_input_unit
  import gpio_input_unit_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] pa_pin,
  input  logic [DATA_WIDTH-1:0] pb_pin,
  input  logic [DATA_WIDTH-1:0] mem_pcmsk0,
  input  logic [DATA_WIDTH-1:0] mem_pcmsk1,
  input  logic [1:0]            mem_pcicr,
  input  logic                  pcifr_wr,
  input  logic [1:0]            pcifr_wdata,
  input  logic [1:0]            irq_ack,
  output logic [DATA_WIDTH-1:0] pina,
  output logic [DATA_WIDTH-1:0] pinb,
  output logic [1:0]            pcif,
  output logic [1:0]            pcint_req
);

  localparam int PRIME = SYNC_STAGES + 1;
  localparam int CW    = $clog2(PRIME + 1);

  logic [CW-1:0] r_prime;
  logic [1:0]    r_pcif;
  logic          w_primed;
  logic          w_chg_a;
  logic          w_chg_b;
  logic [1:0]    w_set;
  logic [1:0]    w_clr;

  gpio_sync_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_a (
    .clk   (clk),
    .reset (reset),
    .i_pin (pa_pin),
    .i_mask(mem_pcmsk0),
    .o_pin (pina),
    .o_chg (w_chg_a)
  );

  gpio_sync_edge #(
    .DATA_WIDTH (DATA_WIDTH),
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync_b (
    .clk   (clk),
    .reset (reset),
    .i_pin (pb_pin),
    .i_mask(mem_pcmsk1),
    .o_pin (pinb),
    .o_chg (w_chg_b)
  );

  // Hold off detection until the pipeline holds real pin samples.
  assign w_primed = (r_prime == CW'(PRIME));

  assign w_set[PCIF0_BIT] = w_chg_a & w_primed;
  assign w_set[PCIF1_BIT] = w_chg_b & w_primed;
  assign w_clr = irq_ack | ({2{pcifr_wr}} & pcifr_wdata);

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_prime <= '0;
      r_pcif  <= '0;
    end else begin
      if (!w_primed)
        r_prime <= r_prime + CW'(1);
      for (int k = 0; k < 2; k++)
        r_pcif[k] <= flag_next(r_pcif[k], w_set[k], w_clr[k]);
    end
  end

  assign pcif = r_pcif;
  assign pcint_req[PCIF0_BIT] = r_pcif[PCIF0_BIT] & mem_pcicr[PCIE0_BIT];
  assign pcint_req[PCIF1_BIT] = r_pcif[PCIF1_BIT] & mem_pcicr[PCIE1_BIT];

endmodule

// File: tb/tb_gpio_input_unit.sv
// Bench for gpio_input_unit: directed scenarios plus random
// traffic against a sample-history reference model.
module tb_gpio_input_unit;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pa_pin, pb_pin;
  logic [W-1:0] mem_pcmsk0, mem_pcmsk1;
  logic [1:0]   mem_pcicr;
  logic         pcifr_wr;
  logic [1:0]   pcifr_wdata;
  logic [1:0]   irq_ack;
  logic [W-1:0] pina, pinb;
  logic [1:0]   pcif, pcint_req;

  int n_chk = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  gpio_input_unit #(
    .DATA_WIDTH (W),
    .SYNC_STAGES(S)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pa_pin     (pa_pin),
    .pb_pin     (pb_pin),
    .mem_pcmsk0 (mem_pcmsk0),
    .mem_pcmsk1 (mem_pcmsk1),
    .mem_pcicr  (mem_pcicr),
    .pcifr_wr   (pcifr_wr),
    .pcifr_wdata(pcifr_wdata),
    .irq_ack    (irq_ack),
    .pina       (pina),
    .pinb       (pinb),
    .pcif       (pcif),
    .pcint_req  (pcint_req)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: history of pin values captured since reset.
  // Visible level = sample S edges back; a change is a difference
  // between the samples S and S+1 edges back.
  logic [W-1:0] qa[$];
  logic [W-1:0] qb[$];
  logic [1:0]   ef;

  function automatic logic [W-1:0] val(input logic [W-1:0] q[$],
                                       input int k);
    if (q.size() >= k) return q[q.size()-k];
    return '0;
  endfunction

  always @(posedge clk) begin
    logic       s0, s1;
    logic [1:0] c;
    if (!reset) begin
      qa.delete();
      qb.delete();
      ef = 2'b00;
    end else begin
      s0 = (qa.size() > S) &&
           (|((val(qa, S) ^ val(qa, S+1)) & mem_pcmsk0));
      s1 = (qb.size() > S) &&
           (|((val(qb, S) ^ val(qb, S+1)) & mem_pcmsk1));
      c  = irq_ack | (pcifr_wr ? pcifr_wdata : 2'b00);
      ef = {s1, s0} | (ef & ~c);
      qa.push_back(pa_pin);
      qb.push_back(pb_pin);
      if (qa.size() > S+1) void'(qa.pop_front());
      if (qb.size() > S+1) void'(qb.pop_front());
    end
  end

  task automatic step();
    @(negedge clk);
    chk("pina", 32'(pina), 32'(val(qa, S)));
    chk("pinb", 32'(pinb), 32'(val(qb, S)));
    chk("pcif", 32'(pcif), 32'(ef));
    chk("req", 32'(pcint_req), 32'(ef & mem_pcicr));
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  initial begin
    reset       = 1'b0;
    pa_pin      = 8'hFF;
    pb_pin      = 8'h00;
    mem_pcmsk0  = 8'hFF;
    mem_pcmsk1  = 8'h00;
    mem_pcicr   = 2'b00;
    pcifr_wr    = 1'b0;
    pcifr_wdata = 2'b00;
    irq_ack     = 2'b00;
    steps(2);
    chk("rst_pcif", 32'(pcif), 32'h0);
    chk("rst_pina", 32'(pina), 32'h0);
    chk("rst_req", 32'(pcint_req), 32'h0);

    // pins high through reset: visible after 2 edges, no flag
    reset = 1'b1;
    steps(2);
    chk("prime_pina", 32'(pina), 32'hFF);
    for (int i = 0; i < 20; i++) begin
      step();
      chk("prime_pcif", 32'(pcif), 32'h0);
    end

    // masked rising edge on pa[2]
    mem_pcmsk0 = 8'h00;
    pa_pin     = 8'h00;
    steps(4);
    mem_pcmsk0 = 8'h04;
    mem_pcicr  = 2'b01;
    steps(2);
    chk("mask_on_quiet", 32'(pcif), 32'h0);
    pa_pin = 8'h04;
    steps(2);
    chk("lat_early", 32'(pcif[0]), 32'h0);
    step();
    chk("lat_pcif0", 32'(pcif[0]), 32'h1);
    chk("lat_req0", 32'(pcint_req[0]), 32'h1);
    pcifr_wr    = 1'b1;
    pcifr_wdata = 2'b01;
    step();
    pcifr_wr    = 1'b0;
    pcifr_wdata = 2'b00;
    chk("wr_clr_pcif0", 32'(pcif[0]), 32'h0);
    chk("wr_clr_req0", 32'(pcint_req[0]), 32'h0);

    // unmasked pa[3] toggles: level follows, no flag
    pa_pin = 8'h0C;
    steps(2);
    chk("unmask_pina3", 32'(pina[3]), 32'h1);
    steps(3);
    chk("unmask_pcif", 32'(pcif), 32'h0);

    // PCIE1 gates only the request
    mem_pcmsk1 = 8'h01;
    pb_pin     = 8'h01;
    steps(3);
    chk("pb_pcif1", 32'(pcif[1]), 32'h1);
    chk("pb_req1_off", 32'(pcint_req[1]), 32'h0);
    mem_pcicr = 2'b11;
    #1;
    chk("pb_req1_on", 32'(pcint_req[1]), 32'h1);

    // set and ack coinciding: set wins
    pcifr_wr    = 1'b1;
    pcifr_wdata = 2'b11;
    step();
    pcifr_wr    = 1'b0;
    pcifr_wdata = 2'b00;
    pa_pin      = 8'h08;
    steps(2);
    irq_ack = 2'b01;
    step();
    chk("ack_vs_set", 32'(pcif[0]), 32'h1);
    step();
    irq_ack = 2'b00;
    chk("ack_alone", 32'(pcif[0]), 32'h0);

    // both flags set, then reset drops everything
    pa_pin = 8'h0C;
    pb_pin = 8'h00;
    steps(3);
    chk("both_flags", 32'(pcif), 32'h3);
    reset = 1'b0;
    step();
    chk("mid_rst_pcif", 32'(pcif), 32'h0);
    chk("mid_rst_pina", 32'(pina), 32'h0);
    chk("mid_rst_pinb", 32'(pinb), 32'h0);
    pa_pin     = 8'hFF;
    pb_pin     = 8'hFF;
    mem_pcmsk0 = 8'hFF;
    mem_pcmsk1 = 8'hFF;
    reset      = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      chk("rerelease_pcif", 32'(pcif), 32'h0);
    end

    // random traffic against the model
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) pa_pin ^= 8'($urandom);
      if ($urandom_range(0, 2) == 0) pb_pin ^= 8'($urandom);
      if ($urandom_range(0, 9) == 0) mem_pcmsk0 = 8'($urandom);
      if ($urandom_range(0, 9) == 0) mem_pcmsk1 = 8'($urandom);
      mem_pcicr   = 2'($urandom);
      pcifr_wr    = ($urandom_range(0, 5) == 0);
      pcifr_wdata = 2'($urandom);
      irq_ack     = ($urandom_range(0, 5) == 0) ? 2'($urandom) : 2'b00;
      reset       = ($urandom_range(0, 59) != 0);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
